// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    localparam logic [1:0] ST_B = 2'b01;
    localparam logic [1:0] ST_H = 2'b10;
    localparam logic [1:0] ST_W = 2'b11;

    localparam logic [2:0] RD_B = 3'b001;
    localparam logic [2:0] RD_H = 3'b010;
    localparam logic [2:0] RD_W = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_e;

    typedef enum logic {
        CORE = 1'b0,
        DMA  = 1'b1
    } owner_t;

    // Illegal size, misaligned half/word, or address beyond the array.
    function automatic logic req_err(input logic [1:0]  size,
                                     input logic [31:0] addr,
                                     input logic [31:0] mem_bytes);
        return (size == 2'b11)
            || ((size == SZ_H) && addr[0])
            || ((size == SZ_W) && (addr[1:0] != 2'b00))
            || (addr >= mem_bytes);
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load-data extension: selects the low byte/half of the raw memory word and
// sign- or zero-extends it; words pass through.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    logic w_sign_b;
    logic w_sign_h;

    assign w_sign_b = ~i_unsigned & i_raw[7];
    assign w_sign_h = ~i_unsigned & i_raw[15];

    always_comb begin
        o_data = i_raw;
        case (i_size)
            SZ_B:    o_data = {{24{w_sign_b}}, i_raw[7:0]};
            SZ_H:    o_data = {{16{w_sign_h}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core / debug-DMA) arbiter and access controller for the data memory.
// One access in flight at a time: IDLE -> ISSUE -> RESP, or IDLE -> RESP on error.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 2048,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              c_req_valid,
    output logic              c_req_ready,
    input  logic              c_req_we,
    input  logic [1:0]        c_req_size,
    input  logic              c_req_unsigned,
    input  logic [ADDR_W-1:0] c_req_addr,
    input  logic [31:0]       c_req_wdata,
    output logic              c_rsp_valid,
    output logic [31:0]       c_rsp_rdata,
    output logic              c_rsp_err,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [1:0]        d_req_size,
    input  logic              d_req_unsigned,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_rdata,
    output logic              d_rsp_err,

    output logic              mem_re,
    output logic              mem_we,
    output logic [1:0]        mem_store_type,
    output logic [2:0]        mem_read_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            r_state;
    state_e            w_state_next;
    owner_t            r_last;
    owner_t            r_owner;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_err;

    logic              r_mem_re;
    logic              r_mem_we;
    logic [1:0]        r_store_type;
    logic [2:0]        r_read_type;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_idle;
    logic              w_c_grant;
    logic              w_d_grant;
    logic              w_accept;
    logic              w_sel_we;
    logic [1:0]        w_sel_size;
    logic              w_sel_unsigned;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_sel_err;
    logic [1:0]        w_st_type;
    logic [2:0]        w_rd_type;

    logic              w_resp;
    logic [31:0]       w_ext;
    logic [31:0]       w_rsp_data;

    // Round-robin on ties: the port not served last wins.
    assign w_idle    = (r_state == IDLE);
    assign w_c_grant = c_req_valid & (~d_req_valid | (r_last == DMA));
    assign w_d_grant = d_req_valid & (~c_req_valid | (r_last == CORE));

    assign c_req_ready = w_idle & w_c_grant & ~rst;
    assign d_req_ready = w_idle & w_d_grant & ~rst;
    assign w_accept    = c_req_ready | d_req_ready;

    assign w_sel_we       = w_c_grant ? c_req_we       : d_req_we;
    assign w_sel_size     = w_c_grant ? c_req_size     : d_req_size;
    assign w_sel_unsigned = w_c_grant ? c_req_unsigned : d_req_unsigned;
    assign w_sel_addr     = w_c_grant ? c_req_addr     : d_req_addr;
    assign w_sel_wdata    = w_c_grant ? c_req_wdata    : d_req_wdata;

    assign w_sel_err = req_err(w_sel_size, 32'(w_sel_addr), 32'(MEM_BYTES));

    always_comb begin
        w_st_type = ST_W;
        w_rd_type = RD_W;
        case (w_sel_size)
            SZ_B: begin
                w_st_type = ST_B;
                w_rd_type = RD_B;
            end
            SZ_H: begin
                w_st_type = ST_H;
                w_rd_type = RD_H;
            end
            default: begin
                w_st_type = ST_W;
                w_rd_type = RD_W;
            end
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_sel_err ? RESP : ISSUE;
                end
            end
            ISSUE:   w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last       <= DMA;
            r_owner      <= CORE;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_err        <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_store_type <= 2'b00;
            r_read_type  <= 3'b000;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_next;
            // Strobes and type codes are single-cycle: only the ISSUE cycle sees them.
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_store_type <= 2'b00;
            r_read_type  <= 3'b000;
            if (w_accept) begin
                r_owner    <= w_c_grant ? CORE : DMA;
                r_last     <= w_c_grant ? CORE : DMA;
                r_we       <= w_sel_we;
                r_size     <= w_sel_size;
                r_unsigned <= w_sel_unsigned;
                r_err      <= w_sel_err;
                if (!w_sel_err) begin
                    r_mem_addr  <= w_sel_addr;
                    r_mem_wdata <= w_sel_wdata;
                    r_mem_we    <= w_sel_we;
                    r_mem_re    <= ~w_sel_we;
                    if (w_sel_we) begin
                        r_store_type <= w_st_type;
                    end else begin
                        r_read_type <= w_rd_type;
                    end
                end
            end
        end
    end

    assign mem_re         = r_mem_re;
    assign mem_we         = r_mem_we;
    assign mem_store_type = r_store_type;
    assign mem_read_type  = r_read_type;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;

    // The memory only refreshes the bytes it reads, so the upper bits of
    // mem_rdata may be stale; the extender masks them off.
    dmem_load_ext u_load_ext (
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_raw      (mem_rdata),
        .o_data     (w_ext)
    );

    assign w_resp     = (r_state == RESP);
    assign w_rsp_data = (r_we || r_err) ? 32'd0 : w_ext;

    assign c_rsp_valid = w_resp & (r_owner == CORE);
    assign c_rsp_rdata = c_rsp_valid ? w_rsp_data : 32'd0;
    assign c_rsp_err   = c_rsp_valid & r_err;

    assign d_rsp_valid = w_resp & (r_owner == DMA);
    assign d_rsp_rdata = d_rsp_valid ? w_rsp_data : 32'd0;
    assign d_rsp_err   = d_rsp_valid & r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural memory and
// a transaction-level reference model of arbitration, checking and extension.
module tb_dmem_arbiter;

    localparam int MEM_BYTES = 2048;
    localparam int ADDR_W    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;

    logic              c_req_valid = 1'b0;
    logic              c_req_ready;
    logic              c_req_we = 1'b0;
    logic [1:0]        c_req_size = 2'b00;
    logic              c_req_unsigned = 1'b0;
    logic [ADDR_W-1:0] c_req_addr = '0;
    logic [31:0]       c_req_wdata = '0;
    logic              c_rsp_valid;
    logic [31:0]       c_rsp_rdata;
    logic              c_rsp_err;

    logic              d_req_valid = 1'b0;
    logic              d_req_ready;
    logic              d_req_we = 1'b0;
    logic [1:0]        d_req_size = 2'b00;
    logic              d_req_unsigned = 1'b0;
    logic [ADDR_W-1:0] d_req_addr = '0;
    logic [31:0]       d_req_wdata = '0;
    logic              d_rsp_valid;
    logic [31:0]       d_rsp_rdata;
    logic              d_rsp_err;

    logic              mem_re;
    logic              mem_we;
    logic [1:0]        mem_store_type;
    logic [2:0]        mem_read_type;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    dmem_arbiter #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .c_req_valid    (c_req_valid),
        .c_req_ready    (c_req_ready),
        .c_req_we       (c_req_we),
        .c_req_size     (c_req_size),
        .c_req_unsigned (c_req_unsigned),
        .c_req_addr     (c_req_addr),
        .c_req_wdata    (c_req_wdata),
        .c_rsp_valid    (c_rsp_valid),
        .c_rsp_rdata    (c_rsp_rdata),
        .c_rsp_err      (c_rsp_err),
        .d_req_valid    (d_req_valid),
        .d_req_ready    (d_req_ready),
        .d_req_we       (d_req_we),
        .d_req_size     (d_req_size),
        .d_req_unsigned (d_req_unsigned),
        .d_req_addr     (d_req_addr),
        .d_req_wdata    (d_req_wdata),
        .d_rsp_valid    (d_rsp_valid),
        .d_rsp_rdata    (d_rsp_rdata),
        .d_rsp_err      (d_rsp_err),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .mem_store_type (mem_store_type),
        .mem_read_type  (mem_read_type),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural data memory: no reset, registered read that refreshes only
    // the bytes being read.
    logic [7:0]  env_mem [MEM_BYTES] = '{default: 8'h00};
    logic [31:0] d_out = 32'd0;
    assign mem_rdata = d_out;

    function automatic int type_bytes(input logic [2:0] t);
        return (t == 3'd3) ? 4 : ((t == 3'd2) ? 2 : ((t == 3'd1) ? 1 : 0));
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < type_bytes({1'b0, mem_store_type}); i++)
                env_mem[(int'(mem_addr) + i) % MEM_BYTES] <= mem_wdata[8*i +: 8];
        end
        if (mem_re) begin
            for (int i = 0; i < type_bytes(mem_read_type); i++)
                d_out[8*i +: 8] <= env_mem[(int'(mem_addr) + i) % MEM_BYTES];
        end
    end

    // Reference model state and scoreboard queues.
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [2:0]  typ;
        logic [15:0] addr;
        logic [31:0] wdata;
        int unsigned cyc;
    } iss_t;

    logic [7:0]  ref_mem [MEM_BYTES] = '{default: 8'h00};
    rsp_t        rq [2][$];
    iss_t        iq [$];
    bit          last_dma = 1'b1;
    int unsigned free_cyc = 0;

    int n_vec = 0;
    int n_err = 0;

    bit zero_req  = 1'b0;
    bit final_req = 1'b0;
    int c_to_cnt  = 0;
    int d_to_cnt  = 0;
    int c_to_seen = 0;
    int d_to_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input int p, input logic we, input logic [1:0] sz,
                                input logic uns, input logic [15:0] addr,
                                input logic [31:0] wd);
        int          a;
        int          n;
        bit          err;
        rsp_t        r;
        iss_t        e;
        logic [31:0] v;
        logic [31:0] mask;
        a   = int'(addr);
        n   = 1 << sz;
        err = (sz == 2'd3) || ((a % n) != 0) || (a >= MEM_BYTES);
        r.err   = err;
        r.rdata = 32'd0;
        r.cyc   = cyc + (err ? 1 : 2);
        if (!err) begin
            e.we = we;
            e.typ = 3'(sz) + 3'd1;
            e.addr = addr;
            e.wdata = wd;
            e.cyc = cyc + 1;
            iq.push_back(e);
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
                if (n < 4 && !uns && v[8*n-1]) begin
                    mask = (32'd1 << (8 * n)) - 32'd1;
                    v = v | ~mask;
                end
                r.rdata = v;
            end
        end
        rq[p].push_back(r);
        last_dma = (p == 1);
        free_cyc = cyc + (err ? 2 : 3);
    endtask

    task automatic mon_rsp(input int p, input logic v, input logic [31:0] rd, input logic er);
        rsp_t r;
        string pn;
        pn = (p == 0) ? "c" : "d";
        if (v) begin
            chk({pn, "_rsp_expected"}, 32'(rq[p].size() != 0), 32'd1);
            if (rq[p].size() != 0) begin
                r = rq[p].pop_front();
                chk({pn, "_rsp_cycle"}, cyc, r.cyc);
                chk({pn, "_rsp_rdata"}, rd, r.rdata);
                chk({pn, "_rsp_err"}, 32'(er), 32'(r.err));
            end
        end else if (rq[p].size() != 0 && rq[p][0].cyc == cyc) begin
            chk({pn, "_rsp_missing"}, 32'(v), 32'd1);
            void'(rq[p].pop_front());
        end
    endtask

    // Monitor: all comparisons happen here, away from the active edge.
    always @(negedge clk) begin : monitor
        iss_t e;
        logic exp_c;
        logic exp_d;
        if (mem_re || mem_we) begin
            chk("mem_re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
            chk("mem_access_expected", 32'(iq.size() != 0), 32'd1);
            if (iq.size() != 0) begin
                e = iq.pop_front();
                chk("issue_cycle", cyc, e.cyc);
                chk("mem_we", 32'(mem_we), 32'(e.we));
                chk("mem_store_type", 32'(mem_store_type), e.we ? 32'(e.typ[1:0]) : 32'd0);
                chk("mem_read_type", 32'(mem_read_type), e.we ? 32'd0 : 32'(e.typ));
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            end
        end else if (iq.size() != 0 && iq[0].cyc == cyc) begin
            chk("mem_access_missing", 32'(mem_re | mem_we), 32'd1);
            void'(iq.pop_front());
        end
        mon_rsp(0, c_rsp_valid, c_rsp_rdata, c_rsp_err);
        mon_rsp(1, d_rsp_valid, d_rsp_rdata, d_rsp_err);

        if (rst) begin
            chk("ready_in_reset", 32'({c_req_ready, d_req_ready}), 32'd0);
            rq[0].delete();
            rq[1].delete();
            iq.delete();
            last_dma = 1'b1;
            free_cyc = cyc + 1;
        end else begin
            exp_c = (cyc >= free_cyc) && c_req_valid && (!d_req_valid || last_dma);
            exp_d = (cyc >= free_cyc) && d_req_valid && (!c_req_valid || !last_dma);
            chk("c_req_ready", 32'(c_req_ready), 32'(exp_c));
            chk("d_req_ready", 32'(d_req_ready), 32'(exp_d));
            if (c_req_valid && c_req_ready)
                model_accept(0, c_req_we, c_req_size, c_req_unsigned, c_req_addr, c_req_wdata);
            else if (d_req_valid && d_req_ready)
                model_accept(1, d_req_we, d_req_size, d_req_unsigned, d_req_addr, d_req_wdata);
        end

        if (zero_req) begin
            chk("zero_c_req_ready", 32'(c_req_ready), 32'd0);
            chk("zero_d_req_ready", 32'(d_req_ready), 32'd0);
            chk("zero_c_rsp", {c_rsp_rdata[30:0], c_rsp_valid} | 32'(c_rsp_err), 32'd0);
            chk("zero_d_rsp", {d_rsp_rdata[30:0], d_rsp_valid} | 32'(d_rsp_err), 32'd0);
            chk("zero_c_rsp_rdata", c_rsp_rdata, 32'd0);
            chk("zero_d_rsp_rdata", d_rsp_rdata, 32'd0);
            chk("zero_mem_strobes", 32'({mem_re, mem_we}), 32'd0);
            chk("zero_mem_types", 32'({mem_store_type, mem_read_type}), 32'd0);
            chk("zero_mem_addr", 32'(mem_addr), 32'd0);
            chk("zero_mem_wdata", mem_wdata, 32'd0);
        end
        if (c_to_cnt != c_to_seen) begin
            chk("c_accept_timeout", 32'(c_to_cnt), 32'(c_to_seen));
            c_to_seen = c_to_cnt;
        end
        if (d_to_cnt != d_to_seen) begin
            chk("d_accept_timeout", 32'(d_to_cnt), 32'(d_to_seen));
            d_to_seen = d_to_cnt;
        end
        if (final_req) begin
            chk("c_rsp_outstanding", 32'(rq[0].size()), 32'd0);
            chk("d_rsp_outstanding", 32'(rq[1].size()), 32'd0);
            chk("issue_outstanding", 32'(iq.size()), 32'd0);
        end
    end

    // Drivers: called at posedge+1, hold the request until ready is seen.
    task automatic c_send(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [15:0] a, input logic [31:0] wd);
        bit got = 1'b0;
        c_req_we = we; c_req_size = sz; c_req_unsigned = uns;
        c_req_addr = a; c_req_wdata = wd; c_req_valid = 1'b1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = c_req_ready;
        end
        if (!got) c_to_cnt++;
        @(posedge clk);
        #1;
        c_req_valid = 1'b0;
    endtask

    task automatic d_send(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [15:0] a, input logic [31:0] wd);
        bit got = 1'b0;
        d_req_we = we; d_req_size = sz; d_req_unsigned = uns;
        d_req_addr = a; d_req_wdata = wd; d_req_valid = 1'b1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = d_req_ready;
        end
        if (!got) d_to_cnt++;
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_next;
        zero_req = 1'b1;
        @(posedge clk);
        #1;
        zero_req = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check_zero_next();
    endtask

    task automatic rand_req(output logic we, output logic [1:0] sz, output logic uns,
                            output logic [15:0] a, output logic [31:0] wd);
        logic [15:0] align;
        we  = 1'($urandom_range(0, 1));
        sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        uns = 1'($urandom_range(0, 1));
        wd  = $urandom;
        if ($urandom_range(0, 9) == 0) begin
            a = 16'($urandom);
        end else begin
            align = (16'd1 << sz) - 16'd1;
            a = 16'($urandom_range(0, 255)) & ~align;
        end
    endtask

    initial begin
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [15:0] a;
        logic [31:0] wd;

        do_reset();

        // Word store then load; byte sign/zero extension.
        c_send(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
        c_send(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
        c_send(1'b1, 2'd0, 1'b0, 16'h0021, 32'h00000080);
        c_send(1'b0, 2'd0, 1'b0, 16'h0021, 32'h0);
        c_send(1'b0, 2'd0, 1'b1, 16'h0021, 32'h0);

        // Tie from reset: core, dma, core, dma.
        do_reset();
        fork
            begin
                c_send(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
                c_send(1'b1, 2'd1, 1'b0, 16'h0030, 32'h00005A5A);
            end
            begin
                d_send(1'b0, 2'd0, 1'b0, 16'h0010, 32'h0);
                d_send(1'b0, 2'd1, 1'b0, 16'h0030, 32'h0);
            end
        join

        // Errors: misaligned half, out-of-range word store, illegal size.
        c_send(1'b0, 2'd1, 1'b0, 16'h0003, 32'h0);
        d_send(1'b1, 2'd2, 1'b0, 16'h0800, 32'h11111111);
        c_send(1'b0, 2'd3, 1'b0, 16'h0004, 32'h0);
        c_send(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0);

        // Reset during the ISSUE cycle of a dma store; the store still lands.
        d_send(1'b1, 2'd2, 1'b0, 16'h0040, 32'h12345678);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_zero_next();
        c_send(1'b0, 2'd2, 1'b0, 16'h0040, 32'h0);

        // Half loads after a word load leaves 0xFFFF in the upper bytes.
        c_send(1'b1, 2'd2, 1'b0, 16'h0200, 32'hFFFF1234);
        c_send(1'b0, 2'd2, 1'b0, 16'h0200, 32'h0);
        c_send(1'b1, 2'd1, 1'b0, 16'h0100, 32'h0000ABCD);
        c_send(1'b0, 2'd1, 1'b0, 16'h0100, 32'h0);
        c_send(1'b0, 2'd1, 1'b1, 16'h0100, 32'h0);

        // Random traffic from both ports.
        fork
            begin
                logic        cwe;
                logic [1:0]  csz;
                logic        cuns;
                logic [15:0] ca;
                logic [31:0] cwd;
                for (int i = 0; i < 150; i++) begin
                    idle($urandom_range(0, 3));
                    rand_req(cwe, csz, cuns, ca, cwd);
                    c_send(cwe, csz, cuns, ca, cwd);
                end
            end
            begin
                logic        dwe;
                logic [1:0]  dsz;
                logic        duns;
                logic [15:0] da;
                logic [31:0] dwd;
                for (int i = 0; i < 150; i++) begin
                    idle($urandom_range(0, 3));
                    rand_req(dwe, dsz, duns, da, dwd);
                    d_send(dwe, dsz, duns, da, dwd);
                end
            end
        join

        // Read back a spread of locations touched by the random phase.
        for (int i = 0; i < 16; i++) begin
            rand_req(we, sz, uns, a, wd);
            c_send(1'b0, 2'd2, uns, 16'(i * 16), 32'h0);
        end

        idle(8);
        final_req = 1'b1;
        idle(1);
        final_req = 1'b0;
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester access controller for the byte-addressable data memory. Arbitrates between the core load/store unit (port `c_`) and a debug/DMA port (`d_`), checks size, alignment and range, then drives the memory's read/write strobes and type codes. Sign- or zero-extends load data and returns one response pulse per accepted request. Sits between the MEM pipeline stage / debug unit and `data_memory`.

## Interface
- `MEM_BYTES`, 2048: memory size in bytes; must be a multiple of 4.
- `ADDR_W`, 16: address width.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `c_req_valid`/`d_req_valid` in 1: request present.
- `c_req_ready`/`d_req_ready` out 1: request accepted this cycle when high together with valid.
- `c_req_we`/`d_req_we` in 1: 1 = store, 0 = load.
- `c_req_size`/`d_req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `c_req_unsigned`/`d_req_unsigned` in 1: zero-extend loads (lbu/lhu).
- `c_req_addr`/`d_req_addr` in ADDR_W: byte address.
- `c_req_wdata`/`d_req_wdata` in 32: store data, LSB-aligned.
- `c_rsp_valid`/`d_rsp_valid` out 1: one-cycle response pulse.
- `c_rsp_rdata`/`d_rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `c_rsp_err`/`d_rsp_err` out 1: qualified by rsp_valid.
- `mem_re`, `mem_we` out 1: memory strobes.
- `mem_store_type` out 2: 01 byte, 10 half, 11 word.
- `mem_read_type` out 3: 001 byte, 010 half, 011 word. Codes 100 and 101 are never issued.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory `d_out`, registered one cycle after `mem_re`.

## Operation
- **States:** IDLE, ISSUE, RESP.
- **IDLE:** compute the grant. If only one port is valid, grant it. If both are valid, grant the port not served last. The last-served pointer resets to "dma", so the core wins the first tie. `req_ready` = IDLE & grant & !rst; at most one ready is high. On acceptance, latch owner, we, size, unsigned, addr and wdata, and update the pointer.
- **Error check at acceptance:**
  - size = 11 is an error.
  - Half with addr[0] != 0 is an error.
  - Word with addr[1:0] != 0 is an error.
  - addr >= MEM_BYTES is an error.
  - An erroring request goes IDLE -> RESP with err = 1 and makes no memory access.
- **ISSUE:** registered outputs hold `mem_addr`/`mem_wdata` from the latch. Store: `mem_we` = 1, `mem_store_type` = size + 1. Load: `mem_re` = 1, `mem_read_type` = size + 1. Then go to RESP.
- **RESP:** pulse the owner's `rsp_valid`; the other port's rsp stays 0.
  - Loads use `mem_rdata`, because the memory leaves upper bytes stale. Byte: take [7:0], then sign- or zero-extend. Half: take [15:0], then extend. Word: pass through.
  - Then go to IDLE. There is no response backpressure.
- `mem_re` and `mem_we` are never both high. Both are 0 outside ISSUE.

## Timing
- **Reset values:** state IDLE, pointer = dma, and every output is 0. That covers `mem_re`, `mem_we`, `mem_store_type`, `mem_read_type`, `mem_addr`, `mem_wdata`, both rsp_valid, rsp_rdata, rsp_err and both req_ready.
- **Normal request:** accepted at the edge closing cycle T. ISSUE is cycle T+1, RESP (rsp_valid) is cycle T+2, IDLE is cycle T+3. The next acceptance is no earlier than T+3, so throughput is one access per 3 cycles.
- **Error request:** accepted at T, rsp_valid with err at T+1, IDLE at T+2.
- **Store visibility:** memory is updated at the edge ending ISSUE. A load accepted later reads the new value.
- **Requester rules:** a requester must hold its request stable until ready. A withdrawn valid in IDLE just re-arbitrates the next cycle.
- **Reset mid-operation:** at the reset edge, state goes to IDLE and no response is produced. A store in ISSUE at that edge still commits, because the memory has no reset. The bench must tolerate this.
- **Simultaneous events:** a request that becomes valid during ISSUE or RESP waits for IDLE. With two valid requests in IDLE, exactly one is accepted.

## Structure
- **`dmem_pkg`:**
  - size enum (`SZ_B`, `SZ_H`, `SZ_W`).
  - store-type constants (`ST_B`/`ST_H`/`ST_W` = 01/10/11).
  - read-type constants (`RD_B`/`RD_H`/`RD_W` = 001/010/011).
  - state enum (IDLE/ISSUE/RESP).
  - `owner_t` (CORE/DMA).
- **Sub-module `dmem_load_ext`:** purely combinational (size, unsigned, raw 32 -> extended 32). Instantiated once on the RESP path and unit-testable alone.

## Test plan
- **Core store word, then load word:** core stores word 0xDEADBEEF at 0x0010, then loads word at 0x0010. Expected: `mem_we` with store_type 11 at T+1; the load's rsp_rdata = 0xDEADBEEF at its T+2; err = 0.
- **Signed vs unsigned byte load:** store byte 0x80 at 0x0021. Load byte signed -> 0xFFFFFF80. Load byte unsigned -> 0x00000080. Only read_type 001 is observed.
- **Round-robin tie:** both ports valid for 4 consecutive requests from reset. Grant order is core, dma, core, dma. Exactly one ready per IDLE cycle, and rsp goes only to the owner.
- **Error requests:**
  - Half load at 0x0003 -> err = 1 at T+1, with no `mem_re`/`mem_we` pulse.
  - Word store at 0x0800 -> err = 1, memory unchanged.
  - size = 11 -> err = 1.
- **Reset mid-operation:** assert rst during ISSUE of a dma word store of 0x12345678 to 0x0040. Expected: no rsp_valid and all outputs 0 the next cycle. A subsequent core load of 0x0040 returns 0x12345678.
- **Half loads and stale upper bytes:** store half 0xABCD at 0x0100, after a prior word load left `mem_rdata`[31:16] = 0xFFFF. Signed half load -> 0xFFFFABCD; unsigned half load -> 0x0000ABCD.
